split_bus_arbiter: RTL
======================

SPLIT_BUS_ARBITER -- requirements
Module: split_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: max cycles a grant may be held without completion before forced release.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port init1_req  input  1  initiator 1 requests bus.
REQ-005 SHALL have port init2_req  input  1  initiator 2 requests bus.
REQ-006 SHALL have port split_target_req  input  1  split target requests bus to return deferred read data.
REQ-007 SHALL have port txn_done  input  1  one-cycle pulse: current transaction completed (target ack).
REQ-008 SHALL have port split_ack  input  1  one-cycle pulse: addressed target deferred current transaction.
REQ-009 SHALL have port init1_grant  output  1  bus granted to initiator 1.
REQ-010 SHALL have port init2_grant  output  1  bus granted to initiator 2.
REQ-011 SHALL have port split_target_grant  output  1  bus granted to split target.
REQ-012 SHALL have port owner_sel  output  2  datapath mux select: 0 none, 1 init1, 2 init2, 3 split target.
REQ-013 SHALL have port split_pending  output  1  a deferred transaction is outstanding.
REQ-014 SHALL have port split_owner  output  1  initiator awaiting split data (0 = init1, 1 = init2); valid while split_pending.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY_I1, BUSY_I2, BUSY_SPLIT; grants and owner_sel are registered and decoded from state (at most one grant high).
REQ-017 In IDLE, SHALL arbitrate each cycle; winner's grant asserts the following cycle.
REQ-018 Priority: split_target_req (only when split_pending=1) > init1/init2 round-robin.
REQ-019 Round-robin: on simultaneous init1_req and init2_req, SHALL grant the initiator not granted most recently; pointer resets to favour init1.
REQ-020 While split_pending=1, SHALL not grant the initiator equal to split_owner; the other initiator remains grantable.
REQ-021 split_target_req while split_pending=0 SHALL be ignored.
REQ-022 In BUSY_I1/BUSY_I2: txn_done -> IDLE; split_ack -> IDLE with split_pending<=1 and split_owner<=current initiator; owner req deasserted -> IDLE.
REQ-023 split_ack and txn_done in the same cycle SHALL be treated as split_ack.
REQ-024 split_ack in BUSY_I1/BUSY_I2 while split_pending=1 already SHALL be ignored as a split (single outstanding split) and treated as txn_done.
REQ-025 In BUSY_SPLIT: txn_done -> IDLE and split_pending<=0; split_ack ignored.
REQ-026 Grant SHALL drop the cycle after the terminating event; minimum one IDLE cycle between consecutive grants.
REQ-027 A hold counter SHALL count cycles in any BUSY state, clearing on entry; on reaching TIMEOUT_CYCLES the FSM SHALL go to IDLE and pulse timeout_err for one cycle.
REQ-028 Timeout in BUSY_SPLIT SHALL clear split_pending; timeout in BUSY_I1/BUSY_I2 SHALL not alter split_pending.
REQ-029 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1) bits and SHALL not wrap.

Reset
REQ-030 On rst_n low, SHALL immediately enter IDLE, all grants 0, owner_sel 0, split_pending 0, split_owner 0, timeout_err 0, counter 0, round-robin favouring init1.
REQ-031 Reset mid-transaction SHALL abandon any grant and any outstanding split without further output.
REQ-032 First arbitration SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-033 init1_req=init2_req=1 held, txn_done every grant -> grants alternate init1, init2, init1 with one idle cycle between; owner_sel 1,0,2,0,1.
REQ-034 init1 granted, split_ack -> init1_grant drops next cycle, split_pending=1, split_owner=0; init1_req held and init2_req=1 -> init2 granted, init1 not.
REQ-035 split_pending=1, split_target_req=1 and init2_req=1 in IDLE -> split_target_grant next cycle, owner_sel=3; txn_done -> split_pending=0.
REQ-036 TIMEOUT_CYCLES=8, init2 granted, no txn_done -> grant drops after 8 grant cycles, timeout_err one-cycle pulse.
REQ-037 split_target_req=1 with split_pending=0 -> no grant, state stays IDLE.
REQ-038 rst_n low while BUSY_SPLIT -> all grants 0 and split_pending 0 asynchronously, before next clock edge.

Source files
------------

// File: rtl/split_bus_arbiter.sv
// Three-way bus arbiter: two initiators round-robin plus a split target that returns
// deferred read data. Tracks one outstanding split and force-releases stuck grants.
module split_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init1_req,
    input  logic       init2_req,
    input  logic       split_target_req,
    input  logic       txn_done,
    input  logic       split_ack,
    output logic       init1_grant,
    output logic       init2_grant,
    output logic       split_target_grant,
    output logic [1:0] owner_sel,
    output logic       split_pending,
    output logic       split_owner,
    output logic       timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY_I1    = 2'd1,
        BUSY_I2    = 2'd2,
        BUSY_SPLIT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          favour_i2_q, favour_i2_d;
    logic          split_pending_q, split_pending_d;
    logic          split_owner_q, split_owner_d;
    logic          timeout_err_q, timeout_err_d;
    logic          elig1, elig2, owner_req;

    // The initiator waiting on split data may not start another transaction.
    assign elig1   = init1_req && !(split_pending_q && !split_owner_q);
    assign elig2   = init2_req && !(split_pending_q &&  split_owner_q);
    assign cnt_inc = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CW'(1);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        favour_i2_d     = favour_i2_q;
        split_pending_d = split_pending_q;
        split_owner_d   = split_owner_q;
        timeout_err_d   = 1'b0;
        owner_req       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (split_pending_q && split_target_req) begin
                    state_d = BUSY_SPLIT;
                end else if (elig1 && (!elig2 || !favour_i2_q)) begin
                    state_d     = BUSY_I1;
                    favour_i2_d = 1'b1;
                end else if (elig2) begin
                    state_d     = BUSY_I2;
                    favour_i2_d = 1'b0;
                end
            end
            BUSY_I1, BUSY_I2: begin
                cnt_d     = cnt_inc;
                owner_req = (state_q == BUSY_I1) ? init1_req : init2_req;
                // A second split while one is outstanding is treated as plain completion.
                if (split_ack || txn_done || !owner_req) begin
                    state_d = IDLE;
                    if (split_ack && !split_pending_q) begin
                        split_pending_d = 1'b1;
                        split_owner_d   = (state_q == BUSY_I2);
                    end
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            BUSY_SPLIT: begin
                cnt_d = cnt_inc;
                if (txn_done) begin
                    state_d         = IDLE;
                    split_pending_d = 1'b0;
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_d         = IDLE;
                    split_pending_d = 1'b0;
                    timeout_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking (<=) so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            favour_i2_q     <= 1'b0;
            split_pending_q <= 1'b0;
            split_owner_q   <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            favour_i2_q     <= favour_i2_d;
            split_pending_q <= split_pending_d;
            split_owner_q   <= split_owner_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    always_comb begin
        init1_grant        = 1'b0;
        init2_grant        = 1'b0;
        split_target_grant = 1'b0;
        owner_sel          = 2'd0;
        case (state_q)
            BUSY_I1: begin
                init1_grant = 1'b1;
                owner_sel   = 2'd1;
            end
            BUSY_I2: begin
                init2_grant = 1'b1;
                owner_sel   = 2'd2;
            end
            BUSY_SPLIT: begin
                split_target_grant = 1'b1;
                owner_sel          = 2'd3;
            end
            default: ;
        endcase
    end

    assign split_pending = split_pending_q;
    assign split_owner   = split_owner_q;
    assign timeout_err   = timeout_err_q;

endmodule
